// File: rtl/dr_parity_pkg.sv
// dr_parity_pkg: shared state encoding and dual-rail decode helpers for the parity accumulator.
package dr_parity_pkg;
    typedef enum logic [2:0] {IDLE, EVAL, HOLD, RTZ, ERR} state_t;
    localparam int MAX_W = 64;
    typedef logic [MAX_W-1:0] rail_t;
    function automatic logic dr_spacer(input rail_t t, input rail_t f);
        return ~|(t | f);
    endfunction
    function automatic logic dr_illegal(input rail_t t, input rail_t f);
        return |(t & f);
    endfunction
    // Bits outside the mask count as satisfied so narrow tokens can share the wide helper.
    function automatic logic dr_complete(input rail_t t, input rail_t f, input rail_t mask);
        return &((t ^ f) | ~mask);
    endfunction
endpackage

// File: rtl/dr_parity_accumulator_sync.sv
// dr_sync: per-bit flop chain bringing asynchronous rails into the clk domain.
module dr_sync #(
    parameter int N      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    if (STAGES == 0) begin : g_wire
        assign q = d;
    end else begin : g_ff
        logic [STAGES-1:0][N-1:0] chain_q, chain_d;
        always_comb begin
            chain_d[0] = d;
            for (int i = 1; i < STAGES; i++) chain_d[i] = chain_q[i-1];
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) chain_q <= '0;
            else chain_q <= chain_d;
        end
        assign q = chain_q[STAGES-1];
    end
endmodule

// File: rtl/dr_parity_accumulator.sv
// dr_parity_accumulator: dual-rail running-parity checker with four-phase handshake and sticky protocol error.
module dr_parity_accumulator
    import dr_parity_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int WINDOW      = 0,
    parameter int ODD         = 0,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_t,
    input  logic [WIDTH-1:0] in_f,
    output logic             in_ack,
    output logic             par_t,
    output logic             par_f,
    input  logic             out_ack,
    input  logic             clr_err,
    output logic             err,
    output logic [CNT_W-1:0] tok_cnt
);
    localparam rail_t MASK = {MAX_W{1'b1}} >> (MAX_W - WIDTH);
    localparam logic ODD_B = (ODD != 0);
    logic [2*WIDTH:0] sync_q;
    logic [WIDTH-1:0] t_s, f_s, cap_t_q, cap_t_d, cap_f_q, cap_f_d;
    logic ack_s, spacer, complete, illegal, changed, parity_n, wrap_hit;
    logic parity_q, parity_d, par_t_q, par_t_d, par_f_q, par_f_d;
    logic in_ack_q, in_ack_d, err_q, err_d;
    logic [CNT_W-1:0] tok_cnt_q, tok_cnt_d;
    state_t state_q, state_d;
    dr_sync #(.N(2*WIDTH+1), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({out_ack, in_f, in_t}),
        .q     (sync_q)
    );
    assign {ack_s, f_s, t_s} = sync_q;
    assign spacer   = dr_spacer(MAX_W'(t_s), MAX_W'(f_s));
    assign illegal  = dr_illegal(MAX_W'(t_s), MAX_W'(f_s));
    assign complete = dr_complete(MAX_W'(t_s), MAX_W'(f_s), MASK);
    // Rails may only fall while holding; a newly raised rail means the token changed without a spacer.
    assign changed  = |(t_s & ~cap_t_q) | |(f_s & ~cap_f_q);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cap_t_q   <= '0;
            cap_f_q   <= '0;
            parity_q  <= 1'b0;
            par_t_q   <= 1'b0;
            par_f_q   <= 1'b0;
            in_ack_q  <= 1'b0;
            err_q     <= 1'b0;
            tok_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cap_t_q   <= cap_t_d;
            cap_f_q   <= cap_f_d;
            parity_q  <= parity_d;
            par_t_q   <= par_t_d;
            par_f_q   <= par_f_d;
            in_ack_q  <= in_ack_d;
            err_q     <= err_d;
            tok_cnt_q <= tok_cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = ack_s ? ERR : complete ? EVAL : IDLE;
            EVAL:    state_d = HOLD;
            HOLD:    state_d = changed ? ERR : (spacer && ack_s) ? RTZ : HOLD;
            RTZ:     state_d = ack_s ? RTZ : IDLE;
            ERR:     state_d = (clr_err && spacer) ? IDLE : ERR;
            default: state_d = ERR;
        endcase
        if (illegal) state_d = ERR;
    end
    always_comb begin
        parity_n  = parity_q ^ (^t_s);
        wrap_hit  = (WINDOW != 0) && (tok_cnt_q == CNT_W'(WINDOW - 1));
        cap_t_d   = cap_t_q;
        cap_f_d   = cap_f_q;
        parity_d  = parity_q;
        par_t_d   = par_t_q;
        par_f_d   = par_f_q;
        in_ack_d  = in_ack_q;
        err_d     = err_q;
        tok_cnt_d = tok_cnt_q;
        if (state_d == ERR) begin
            par_t_d   = 1'b0;
            par_f_d   = 1'b0;
            in_ack_d  = 1'b0;
            err_d     = 1'b1;
            parity_d  = 1'b0;
            tok_cnt_d = '0;
        end else if (state_q == EVAL) begin
            cap_t_d  = t_s;
            cap_f_d  = f_s;
            parity_d = parity_n;
            par_t_d  = parity_n ^ ODD_B;
            par_f_d  = ~(parity_n ^ ODD_B);
            in_ack_d = 1'b1;
        end else if (state_q == HOLD && state_d == RTZ) begin
            par_t_d   = 1'b0;
            par_f_d   = 1'b0;
            in_ack_d  = 1'b0;
            tok_cnt_d = wrap_hit ? '0 : tok_cnt_q + 1'b1;
            parity_d  = parity_q & ~wrap_hit;
        end else if (state_q == ERR) begin
            err_d = 1'b0;
        end
    end
    assign par_t   = par_t_q;
    assign par_f   = par_f_q;
    assign in_ack  = in_ack_q;
    assign err     = err_q;
    assign tok_cnt = tok_cnt_q;
endmodule

// File: tb/tb_dr_parity_accumulator.sv
// tb_dr_parity_accumulator: directed vector table plus handshake corner sequences on three configurations.
module tb_dr_parity_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0][7:0] it, ifl;
    logic [2:0] oa, ce, pt, pf, ia, er;
    logic [2:0][15:0] tc;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dr_parity_accumulator #(.WIDTH(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_t(it[0][0]), .in_f(ifl[0][0]), .in_ack(ia[0]),
        .par_t(pt[0]), .par_f(pf[0]), .out_ack(oa[0]), .clr_err(ce[0]), .err(er[0]), .tok_cnt(tc[0])
    );
    dr_parity_accumulator #(.WIDTH(4), .WINDOW(2)) u1 (
        .clk(clk), .rst_n(rst_n), .in_t(it[1][3:0]), .in_f(ifl[1][3:0]), .in_ack(ia[1]),
        .par_t(pt[1]), .par_f(pf[1]), .out_ack(oa[1]), .clr_err(ce[1]), .err(er[1]), .tok_cnt(tc[1])
    );
    dr_parity_accumulator #(.WIDTH(8), .ODD(1), .SYNC_STAGES(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_t(it[2]), .in_f(ifl[2]), .in_ack(ia[2]),
        .par_t(pt[2]), .par_f(pf[2]), .out_ack(oa[2]), .clr_err(ce[2]), .err(er[2]), .tok_cnt(tc[2])
    );

    typedef struct {
        int          s;
        logic [7:0]  t;
        logic [7:0]  f;
        logic        et;
        logic        ef;
        logic [15:0] ec;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ia(input int s, input logic v, input string name);
        int k = 0;
        while (ia[s] !== v && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (ia[s] !== v) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: in_ack stuck at %b, expected %b", name, ia[s], v);
        end
    endtask

    task automatic wait_err(input int s, input logic v, input string name);
        int k = 0;
        while (er[s] !== v && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(er[s]), 32'(v));
    endtask

    task automatic release_hs(input int s);
        it[s] = '0;
        ifl[s] = '0;
        oa[s] = 1'b1;
        wait_ia(s, 1'b0, "ack_fall");
        oa[s] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic token(input int s, input logic [7:0] t, input logic [7:0] f, output logic rt, output logic rf);
        @(negedge clk);
        it[s] = t;
        ifl[s] = f;
        wait_ia(s, 1'b1, "ack_rise");
        rt = pt[s];
        rf = pf[s];
        release_hs(s);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v [8];
        logic rt, rf;
        int bad;
        v[0] = '{0, 8'h01, 8'h00, 1'b1, 1'b0, 16'd1};
        v[1] = '{0, 8'h00, 8'h01, 1'b1, 1'b0, 16'd2};
        v[2] = '{0, 8'h01, 8'h00, 1'b0, 1'b1, 16'd3};
        v[3] = '{1, 8'h0B, 8'h04, 1'b1, 1'b0, 16'd1};
        v[4] = '{1, 8'h01, 8'h0E, 1'b0, 1'b1, 16'd0};
        v[5] = '{1, 8'h01, 8'h0E, 1'b1, 1'b0, 16'd1};
        v[6] = '{2, 8'hFF, 8'h00, 1'b1, 1'b0, 16'd1};
        v[7] = '{2, 8'h07, 8'hF8, 1'b0, 1'b1, 16'd2};
        it = '0;
        ifl = '0;
        oa = '0;
        ce = '0;
        repeat (2) @(negedge clk);
        check("reset_outs", 32'({ia, pt, pf, er}), 32'd0);
        check("reset_cnt", 32'(tc[0] | tc[1] | tc[2]), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            token(v[i].s, v[i].t, v[i].f, rt, rf);
            check($sformatf("vec%0d_par_t", i), 32'(rt), 32'(v[i].et));
            check($sformatf("vec%0d_par_f", i), 32'(rf), 32'(v[i].ef));
            check($sformatf("vec%0d_tok_cnt", i), 32'(tc[v[i].s]), 32'(v[i].ec));
        end

        // Latency through two sync stages: rails appear on the 4th rising edge after the input change.
        @(negedge clk);
        it[2] = 8'h01;
        ifl[2] = 8'hFE;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 3) check("lat3_rails", 32'(pt[2] | pf[2]), 32'd0);
        end
        check("lat4_par_t", 32'(pt[2]), 32'd1);
        check("lat4_par_f", 32'(pf[2]), 32'd0);
        release_hs(2);
        check("lat_tok_cnt", 32'(tc[2]), 32'd3);

        // Slow consumer: nothing may move while out_ack is withheld in HOLD or held high in RTZ.
        @(negedge clk);
        it[0] = 8'h01;
        ifl[0] = 8'h00;
        wait_ia(0, 1'b1, "slow_ack_rise");
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (ia[0] !== 1'b1 || pt[0] !== 1'b1 || pf[0] !== 1'b0) bad++;
        end
        it[0] = '0;
        ifl[0] = '0;
        repeat (10) begin
            @(negedge clk);
            if (ia[0] !== 1'b1 || pt[0] !== 1'b1 || pf[0] !== 1'b0 || tc[0] !== 16'd3) bad++;
        end
        check("hold_stable", 32'(bad), 32'd0);
        oa[0] = 1'b1;
        wait_ia(0, 1'b0, "slow_ack_fall");
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (ia[0] !== 1'b0 || pt[0] !== 1'b0 || pf[0] !== 1'b0 || tc[0] !== 16'd4) bad++;
        end
        check("rtz_stable", 32'(bad), 32'd0);
        oa[0] = 1'b0;
        repeat (4) @(negedge clk);
        token(0, 8'h00, 8'h01, rt, rf);
        check("after_slow_par_t", 32'(rt), 32'd1);
        check("after_slow_tok_cnt", 32'(tc[0]), 32'd5);

        // Token swapped in HOLD without a spacer.
        @(negedge clk);
        it[1] = 8'h01;
        ifl[1] = 8'h0E;
        wait_ia(1, 1'b1, "swap_ack_rise");
        check("swap_pre_par_f", 32'(pf[1]), 32'd1);
        @(negedge clk);
        it[1] = 8'h00;
        ifl[1] = 8'h0F;
        wait_err(1, 1'b1, "swap_err");
        check("swap_outs", 32'({ia[1], pt[1], pf[1]}), 32'd0);
        check("swap_tok_cnt", 32'(tc[1]), 32'd0);
        ce[1] = 1'b1;
        repeat (6) @(negedge clk);
        check("clr_nonspacer_sticky", 32'(er[1]), 32'd1);
        it[1] = '0;
        ifl[1] = '0;
        wait_err(1, 1'b0, "clr_spacer");
        ce[1] = 1'b0;
        repeat (3) @(negedge clk);
        token(1, 8'h01, 8'h0E, rt, rf);
        check("post_err_par_t", 32'(rt), 32'd1);
        check("post_err_par_f", 32'(rf), 32'd0);
        check("post_err_tok_cnt", 32'(tc[1]), 32'd1);

        // Illegal bit in IDLE: err rises on the edge after the sync chain delivers it.
        @(negedge clk);
        it[0] = 8'h01;
        ifl[0] = 8'h01;
        repeat (2) @(negedge clk);
        check("illegal_early", 32'(er[0]), 32'd0);
        @(negedge clk);
        check("illegal_err", 32'(er[0]), 32'd1);
        check("illegal_tok_cnt", 32'(tc[0]), 32'd0);
        ce[0] = 1'b1;
        it[0] = '0;
        ifl[0] = '0;
        wait_err(0, 1'b0, "illegal_clr");
        ce[0] = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of HOLD.
        @(negedge clk);
        it[2] = 8'hFF;
        ifl[2] = 8'h00;
        wait_ia(2, 1'b1, "rst_ack_rise");
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outs", 32'({ia[2], pt[2], pf[2], er[2]}), 32'd0);
        check("async_rst_cnt", 32'(tc[2]), 32'd0);
        it[2] = '0;
        ifl[2] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Consumer acknowledging while nothing is offered.
        oa[2] = 1'b1;
        wait_err(2, 1'b1, "idle_ack_err");
        oa[2] = 1'b0;
        repeat (4) @(negedge clk);
        ce[2] = 1'b1;
        wait_err(2, 1'b0, "idle_ack_clr");
        ce[2] = 1'b0;
        repeat (3) @(negedge clk);
        token(2, 8'hFF, 8'h00, rt, rf);
        check("final_par_t", 32'(rt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
